// File: rtl/return_addr_stack.sv
// Return-address stack: circular LIFO of link addresses with a registered pop result and target check.
// Pop result and mispredict appear one cycle after the request; no back-pressure, overflow drops the oldest entry.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop_valid,
  output logic                       top_valid,
  output logic [AW-1:0]              top_addr,
  output logic                       pred_valid,
  output logic [AW-1:0]              pred_addr,
  input  logic                       check_valid,
  input  logic [AW-1:0]              check_target,
  output logic                       mispredict,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tp;
  logic [CW-1:0] cnt;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;

  logic          stack_empty;
  logic          do_pop;
  logic [PW-1:0] tp_inc;
  logic [PW-1:0] tp_dec;

  assign stack_empty = (cnt == '0);
  assign do_pop      = pop_valid && !stack_empty;
  assign tp_inc      = tp + PW'(1);
  assign tp_dec      = tp - PW'(1);

  assign top_valid = !stack_empty;
  assign top_addr  = mem[tp];
  assign count     = cnt;

  // Storage is not reset; only the slot the current op targets is written.
  always_ff @(posedge clk) begin
    if (!reset && push_valid) begin
      if (do_pop) mem[tp]     <= push_addr;
      else        mem[tp_inc] <= push_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push_valid && !do_pop) begin
      tp <= tp_inc;
      if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
    end else if (do_pop && !push_valid) begin
      tp  <= tp_dec;
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_addr  <= '0;
    end else begin
      pred_valid <= do_pop;
      if (do_pop) pred_addr <= mem[tp];
    end
  end

  // The check always compares against the pend value held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      mispredict <= 1'b0;
    end else begin
      mispredict <= check_valid && (!pend_valid || (check_target != pend_addr));
      if (do_pop) begin
        pend_valid <= 1'b1;
        pend_addr  <= mem[tp];
      end else if (check_valid) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 9;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid;
  logic [AW-1:0] push_addr;
  logic          pop_valid;
  logic          top_valid;
  logic [AW-1:0] top_addr;
  logic          pred_valid;
  logic [AW-1:0] pred_addr;
  logic          check_valid;
  logic [AW-1:0] check_target;
  logic          mispredict;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: stack as a queue, back = top.
  logic [AW-1:0] q[$];
  logic          m_pred_valid;
  logic [AW-1:0] m_pred_addr;
  logic          m_pend_valid;
  logic [AW-1:0] m_pend_addr;
  logic          m_misp;

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_addr(push_addr), .pop_valid(pop_valid),
    .top_valid(top_valid), .top_addr(top_addr),
    .pred_valid(pred_valid), .pred_addr(pred_addr),
    .check_valid(check_valid), .check_target(check_target),
    .mispredict(mispredict), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pred_valid = 1'b0;
    m_pred_addr  = '0;
    m_pend_valid = 1'b0;
    m_pend_addr  = '0;
    m_misp       = 1'b0;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".count"},      32'(count),      32'(q.size()));
    check({ctx, ".top_valid"},  32'(top_valid),  32'(q.size() != 0));
    if (q.size() != 0) check({ctx, ".top_addr"}, 32'(top_addr), 32'(q[$]));
    check({ctx, ".pred_valid"}, 32'(pred_valid), 32'(m_pred_valid));
    check({ctx, ".pred_addr"},  32'(pred_addr),  32'(m_pred_addr));
    check({ctx, ".mispredict"}, 32'(mispredict), 32'(m_misp));
  endtask

  // One clock with the given inputs; model advances at the edge, outputs sampled 1ns later.
  task automatic step(input string ctx, input bit psh, input logic [AW-1:0] pa,
                      input bit pp, input bit chk, input logic [AW-1:0] ct);
    logic [AW-1:0] popped;
    push_valid   = psh;
    push_addr    = pa;
    pop_valid    = pp;
    check_valid  = chk;
    check_target = ct;
    @(posedge clk);
    m_misp = chk && (!m_pend_valid || (ct != m_pend_addr));
    if (pp && q.size() != 0) begin
      popped = q[$];
      if (psh) q[q.size()-1] = pa;
      else     void'(q.pop_back());
      m_pred_valid = 1'b1;
      m_pred_addr  = popped;
      m_pend_valid = 1'b1;
      m_pend_addr  = popped;
    end else begin
      m_pred_valid = 1'b0;
      if (psh) begin
        q.push_back(pa);
        if (q.size() > DEPTH) void'(q.pop_front());
      end
      if (chk) m_pend_valid = 1'b0;
    end
    #1;
    compare_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 0, '0, 0, 0, '0);
  endtask

  // Assert reset mid-cycle (inputs as currently driven, optionally randomised) across one edge.
  task automatic do_reset(input bit rand_in);
    if (rand_in) begin
      push_valid   = 1'($urandom);
      push_addr    = AW'($urandom);
      pop_valid    = 1'($urandom);
      check_valid  = 1'($urandom);
      check_target = AW'($urandom);
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_held");
    reset        = 1'b0;
    push_valid   = 1'b0;
    pop_valid    = 1'b0;
    check_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    push_valid = 1'b0; push_addr = '0; pop_valid = 1'b0;
    check_valid = 1'b0; check_target = '0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset with random inputs, then idle.
    do_reset(1);
    for (int i = 0; i < 3; i++) idle("rst_idle");

    // LIFO order.
    step("lifo_push", 1, 9'h010, 0, 0, '0);
    step("lifo_push", 1, 9'h020, 0, 0, '0);
    step("lifo_push", 1, 9'h030, 0, 0, '0);
    check("lifo_cnt3", 32'(count), 32'd3);
    step("lifo_pop", 0, '0, 1, 0, '0);
    check("lifo_p1", 32'(pred_addr), 32'h030);
    step("lifo_pop", 0, '0, 1, 0, '0);
    check("lifo_p2", 32'(pred_addr), 32'h020);
    step("lifo_pop", 0, '0, 1, 0, '0);
    check("lifo_p3", 32'(pred_addr), 32'h010);
    check("lifo_tv", 32'(top_valid), 32'd0);

    // Overflow: 10 pushes keep the newest 8.
    for (int i = 1; i <= 10; i++) step("ovf_push", 1, AW'(i), 0, 0, '0);
    check("ovf_cnt", 32'(count), 32'd8);
    for (int i = 10; i >= 3; i--) begin
      step("ovf_pop", 0, '0, 1, 0, '0);
      check("ovf_pred", 32'(pred_addr), 32'(i));
    end
    step("ovf_pop9", 0, '0, 1, 0, '0);
    check("ovf_pv9", 32'(pred_valid), 32'd0);
    check("ovf_cnt0", 32'(count), 32'd0);

    // Simultaneous push and pop.
    step("pp_setup", 1, 9'h040, 0, 0, '0);
    step("pp_setup", 1, 9'h050, 0, 0, '0);
    step("pp_both", 1, 9'h060, 1, 0, '0);
    check("pp_pred", 32'(pred_addr), 32'h050);
    check("pp_top", 32'(top_addr), 32'h060);
    check("pp_cnt", 32'(count), 32'd2);
    do_reset(0);
    step("pp_empty", 1, 9'h060, 1, 0, '0);
    check("ppe_top", 32'(top_addr), 32'h060);
    check("ppe_cnt", 32'(count), 32'd1);
    check("ppe_pv", 32'(pred_valid), 32'd0);
    do_reset(0);

    // Check path: hit, miss, and no pending prediction.
    step("chk_push", 1, 9'h100, 0, 0, '0);
    step("chk_pop", 0, '0, 1, 0, '0);
    step("chk_hit", 0, '0, 0, 1, 9'h100);
    check("chk_hit_m", 32'(mispredict), 32'd0);
    step("chk_push", 1, 9'h100, 0, 0, '0);
    step("chk_pop", 0, '0, 1, 0, '0);
    step("chk_miss", 0, '0, 0, 1, 9'h104);
    check("chk_miss_m", 32'(mispredict), 32'd1);
    idle("chk_pulse_end");
    check("chk_pulse", 32'(mispredict), 32'd0);
    step("chk_nopend", 0, '0, 0, 1, 9'h104);
    check("chk_nopend_m", 32'(mispredict), 32'd1);
    idle("chk_idle");

    // Reset during a pop, then a check right after.
    step("rmp_push", 1, 9'h011, 0, 0, '0);
    step("rmp_push", 1, 9'h022, 0, 0, '0);
    step("rmp_push", 1, 9'h033, 0, 0, '0);
    push_valid = 1'b0; pop_valid = 1'b1; check_valid = 1'b0;
    do_reset(0);
    check("rmp_pv", 32'(pred_valid), 32'd0);
    check("rmp_cnt", 32'(count), 32'd0);
    step("rmp_chk", 0, '0, 0, 1, 9'h033);
    check("rmp_m", 32'(mispredict), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit            psh, pp, chk;
      logic [AW-1:0] pa, ct;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        psh = ($urandom_range(0, 99) < 45);
        pp  = ($urandom_range(0, 99) < 40);
        chk = ($urandom_range(0, 99) < 25);
        pa  = AW'($urandom);
        ct  = ($urandom_range(0, 1) == 1) ? m_pend_addr : AW'($urandom);
        step("rand", psh, pa, pp, chk, ct);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Return-address stack (RAS) for the fetch stage: the prediction-side counterpart to the JALR execute path. Calls (JAL/JALR with rd=x1/x5) push the 9-bit link address. Returns (JALR with rs1=x1/x5, rd=x0) pop a predicted target that fetch uses before the ALU resolves the real one. When execute delivers the resolved JALR target, the block compares it with the prediction and raises a registered mispredict pulse.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..32.
- `AW`, 9: address width; matches the PC width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `push_valid` in 1: call retired this cycle; push `push_addr`.
- `push_addr` in AW: link address (PC+4).
- `pop_valid` in 1: return fetched this cycle; pop the top entry.
- `top_valid` out 1: stack non-empty; `top_addr` is meaningful.
- `top_addr` out AW: current top entry, i.e. the predicted return target.
- `pred_valid` out 1: registered; a pop consumed a valid entry last cycle.
- `pred_addr` out AW: registered; the target consumed by that pop.
- `check_valid` in 1: execute resolved a return JALR.
- `check_target` in AW: resolved target, `alur[8:0]`.
- `mispredict` out 1: registered one-cycle pulse on a failed check.
- `count` out $clog2(DEPTH+1): number of live entries.

## Operation
- **Storage:** circular array `mem[DEPTH]`, top pointer `tp` (log2 DEPTH bits), count `cnt`. `top_addr = mem[tp]`; `top_valid = (cnt != 0)`.
- **Push only:** `tp <= tp+1` (mod DEPTH), `mem[tp+1] <= push_addr`, `cnt <= min(cnt+1, DEPTH)`.
  - On overflow (`cnt == DEPTH`) the oldest entry is silently overwritten and `cnt` stays at DEPTH.
- **Pop only, non-empty:** `tp <= tp-1` (mod DEPTH), `cnt <= cnt-1`, `pred_valid <= 1`, `pred_addr <= mem[tp]`.
- **Pop only, empty:** no state change; `pred_valid <= 0`, `pred_addr` holds its old value.
- **Push and pop in the same cycle** (co-routine JALR):
  - Non-empty: `mem[tp] <= push_addr`; `tp` and `cnt` unchanged; `pred_valid <= 1`, `pred_addr <= old mem[tp]`.
  - Empty: behaves as push only, with `pred_valid <= 0`.
- **Neither push nor pop:** `pred_valid <= 0`.
- **Pending prediction:** register `pend_valid`/`pend_addr`.
  - Loaded from the pop result whenever `pred_valid` is being set to 1.
  - Cleared by `check_valid`.
- **Check:** on `check_valid`, `mispredict <= ~pend_valid | (check_target != pend_addr)`; otherwise `mispredict <= 0`.
  - If `check_valid` and a new pop occur in the same cycle, the check uses the old pend value, then pend loads the new pop result.
- **Address arithmetic:** all AW-bit, unsigned. No rebuilding of the stack on mispredict; recovery is fetch's responsibility.

## Timing
- **Reset values:** `tp=0`, `cnt=0`, `count=0`, `top_valid=0`, `top_addr=mem[0]` (mem is not reset; X allowed only while `top_valid=0`), `pred_valid=0`, `pred_addr=0`, `pend_valid=0`, `pend_addr=0`, `mispredict=0`.
- `top_valid`/`top_addr` are combinational from state. A push at edge N is visible at `top_addr` after edge N.
- `pred_valid`/`pred_addr` are valid the cycle after the `pop_valid` cycle.
- `mispredict` asserts the cycle after `check_valid` and lasts exactly one cycle per check.
- Reset asserted mid-operation clears all state immediately (asynchronously). Inputs are ignored while `reset` is high. A pending check is discarded and no mispredict is issued.
- Throughput: one push and/or one pop per cycle, no stalls, no back-pressure.

## Test plan
- **Reset:** assert `reset` with random inputs -> `count=0`, `top_valid=0`, `pred_valid=0`, `mispredict=0`; deassert and idle 3 cycles -> unchanged.
- **LIFO order:** push 0x010, 0x020, 0x030, then pop 3 times -> `pred_addr` = 0x030, 0x020, 0x010 on consecutive cycles with `pred_valid=1`; `count` goes 3 -> 0 and `top_valid` ends at 0.
- **Overflow:** DEPTH=8, push 0x001..0x00A (10 pushes) -> `count=8`; 8 pops return 0x00A down to 0x003; a 9th pop -> `pred_valid=0`, `count=0`.
- **Simultaneous push and pop:** stack [0x040, 0x050 (top)], push 0x060 and pop together -> `pred_addr=0x050`, `top_addr=0x060`, `count=2`. The same stimulus on an empty stack -> `top_addr=0x060`, `count=1`, `pred_valid=0`.
- **Check:** push 0x100, pop, then `check_valid` with target 0x100 -> `mispredict=0`. Repeat with target 0x104 -> one-cycle `mispredict=1`. `check_valid` with no pending prediction -> `mispredict=1`.
- **Reset mid-pop:** 3 entries, assert `reset` during a pop cycle -> `pred_valid=0`, `count=0`; a check issued right after reset -> `mispredict=1`.
